ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte to the keyboard over the same two-wire bus the existing keyboard receiver listens on, e.g. the Scroll Lock LED update after `scrlk` toggles. It drives the clock and data lines open-drain, follows the PS/2 request-to-send sequence, appends odd parity and a stop bit, and checks the device acknowledge. It sits beside the keyboard receiver. Its `busy` output tells the receiver to ignore the bus while a transmission is in progress. The device's 0xFA reply is then decoded by the receiver as normal traffic.

---
 rtl/ps2_pkg.sv | 9 +
 rtl/ps2_line_filter.sv | 31 +++
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encodings, default tick counts and command bytes for the PS/2 host transmitter
package ps2_pkg;
    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE} state_t;
    typedef enum logic [1:0] {L_IDLE, L_CMD, L_ARG, L_WAIT} led_t;
    localparam int INHIBIT_TICKS = 840;
    localparam int TIMEOUT_TICKS = 105000;
    localparam int FILTER_SAMPLES = 4;
    localparam logic [7:0] CMD_LEDS = 8'hED;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer followed by a FILTER-sample debounce on ce
module ps2_line_filter #(
    parameter int FILTER = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic d,
    output logic q
);
    localparam int CW = $clog2(FILTER + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    // idle bus is high, so the synchronizer and filter start at 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
            cnt <= '0;
            q <= 1'b1;
        end else begin
            sync <= {sync[0], d};
            if (ce) begin
                if (sync[1] == q) cnt <= '0;
                else if (cnt == CW'(FILTER - 1)) begin
                    q <= sync[1];
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter; define PS2TX_LED_EN to add the keyboard LED update sequencer
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT = INHIBIT_TICKS,
    parameter int TIMEOUT = TIMEOUT_TICKS,
    parameter int FILTER  = FILTER_SAMPLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2Ck,
    input  logic       ps2Dt,
    output logic       ps2CkOe,
    output logic       ps2DtOe,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error
`ifdef PS2TX_LED_EN
    ,
    input  logic [2:0] leds
`endif
);
    localparam int TW = $clog2((INHIBIT > TIMEOUT ? INHIBIT : TIMEOUT) + 1);
    state_t state, state_n;
    logic [TW-1:0] cnt, cnt_n;
    logic [3:0] n, n_n;
    logic [8:0] sr, sr_n;
    logic done_n, err_n, ck_f, dt_f, ck_q, fall, timed, idle_ok, go;
    logic [7:0] go_data;

    ps2_line_filter #(.FILTER(FILTER)) u_ck (.clock(clock), .reset(reset), .ce(ce), .d(ps2Ck), .q(ck_f));
    ps2_line_filter #(.FILTER(FILTER)) u_dt (.clock(clock), .reset(reset), .ce(ce), .d(ps2Dt), .q(dt_f));

    assign fall = ck_q & ~ck_f;
    assign timed = state != S_IDLE && state != S_INHIBIT;
    assign idle_ok = state == S_IDLE && !done && !error;
    assign busy = state != S_IDLE;
    assign ps2CkOe = state == S_INHIBIT;
    assign ps2DtOe = state == S_REQ || (state == S_SHIFT && !sr[n]);

`ifdef PS2TX_LED_EN
    led_t seq, seq_n;
    logic [2:0] last, last_n, pend, pend_n;
    logic led_go;
    assign go = idle_ok && (start || led_go);
    assign go_data = start ? data : seq == L_IDLE ? CMD_LEDS : {5'b0, pend};
    // LED sequencer: 0xED then the LED byte, yielding to an external start in the same idle cycle
    always_comb begin
        seq_n = seq;
        last_n = last;
        pend_n = pend;
        led_go = 1'b0;
        case (seq)
            L_IDLE: if (idle_ok && !start && leds != last) begin
                led_go = 1'b1;
                pend_n = leds;
                seq_n = L_CMD;
            end
            L_CMD: if (done) seq_n = L_ARG;
                   else if (error) begin
                       last_n = pend;
                       seq_n = L_IDLE;
                   end
            L_ARG: if (idle_ok && !start) begin
                led_go = 1'b1;
                seq_n = L_WAIT;
            end
            L_WAIT: if (done || error) begin
                last_n = pend;
                seq_n = L_IDLE;
            end
            default: seq_n = L_IDLE;
        endcase
    end
    // sequencer state; a failed pair is recorded as sent so it only retries on a new leds value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq <= L_IDLE;
            last <= '0;
            pend <= '0;
        end else begin
            seq <= seq_n;
            last <= last_n;
            pend <= pend_n;
        end
    end
`else
    assign go = idle_ok && start;
    assign go_data = data;
`endif

    // transmit FSM next state: tick counter doubles as inhibit timer and edge-to-edge timeout
    always_comb begin
        state_n = state;
        cnt_n = timed ? (fall ? '0 : cnt + TW'(ce)) : cnt;
        n_n = n;
        sr_n = sr;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            S_IDLE: if (go) begin
                state_n = S_INHIBIT;
                sr_n = {~^go_data, go_data};
                cnt_n = '0;
            end
            S_INHIBIT: begin
                cnt_n = cnt + TW'(ce);
                if (ce && cnt == TW'(INHIBIT - 1)) begin
                    state_n = S_REQ;
                    cnt_n = '0;
                end
            end
            S_REQ: if (fall) begin
                state_n = S_SHIFT;
                n_n = '0;
            end
            S_SHIFT: if (fall) begin
                n_n = n + 4'd1;
                if (n == 4'd8) state_n = S_ACK;
            end
            S_ACK: if (fall) begin
                state_n = dt_f ? S_IDLE : S_WAIT_IDLE;
                err_n = dt_f;
            end
            S_WAIT_IDLE: if (ck_f && dt_f) begin
                state_n = S_IDLE;
                done_n = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (timed && !fall && ce && cnt == TW'(TIMEOUT - 1) && state_n != S_IDLE) begin
            state_n = S_IDLE;
            err_n = 1'b1;
        end
    end

    // state register; done/error are registered so they coincide with busy falling
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt <= '0;
            n <= '0;
            sr <= '0;
            ck_q <= 1'b1;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            n <= n_n;
            sr <= sr_n;
            ck_q <= ck_f;
            done <= done_n;
            error <= err_n;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-model bench with bit and result scoreboards for ps2_host_tx
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 300;
    localparam int H = 40;
    logic clock, reset, ce, start, dev_ck, dev_dt;
    logic [7:0] data;
    logic ps2Ck, ps2Dt, ps2CkOe, ps2DtOe, busy, done, error;
    int ncmp = 0, nfail = 0, ticks, t;
    logic exp_q[$];
    logic [1:0] res_q[$];
`ifdef PS2TX_LED_EN
    logic [2:0] leds = 3'b000;
`endif

    assign ps2Ck = dev_ck & ~ps2CkOe;
    assign ps2Dt = dev_dt & ~ps2DtOe;

    ps2_host_tx #(.INHIBIT(INH), .TIMEOUT(TMO), .FILTER(4)) dut (
        .clock(clock), .reset(reset), .ce(ce), .ps2Ck(ps2Ck), .ps2Dt(ps2Dt),
        .ps2CkOe(ps2CkOe), .ps2DtOe(ps2DtOe), .start(start), .data(data),
        .busy(busy), .done(done), .error(error)
`ifdef PS2TX_LED_EN
        , .leds(leds)
`endif
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        ce = 0;
        forever @(negedge clock) ce = ~ce;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bits(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(($countones(d) % 2) == 0);
        exp_q.push_back(1'b1);
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() == 0) chk(tag, ps2Dt, 1'bx);
        else chk(tag, ps2Dt, exp_q.pop_front());
    endtask

    // res: 0 no pulse expected, 1 done, 2 error
    task automatic send(input logic [7:0] d, input bit bits, input int res);
        int n = 0, k = 0;
        @(negedge clock);
        start = 1;
        data = d;
        if (bits) push_bits(d);
        if (res != 0) res_q.push_back(res == 1 ? 2'b10 : 2'b01);
        @(posedge clock);
        #1 start = 0;
        chk("busy_rise", busy, 1);
        chk("ck_inhibit", ps2CkOe, 1);
        while (ps2CkOe && k < 4 * INH + 20) begin
            @(posedge clock);
            if (ce) n++;
            #1 k++;
        end
        chk("inhibit_ticks", n, INH);
        chk("req_dt", ps2DtOe, 1);
    endtask

    task automatic dev_xfer(input int edges, input bit ack_low);
        int w = 0;
        while (!(ps2DtOe && !ps2CkOe) && w < 5000) begin
            @(negedge clock);
            w++;
        end
        chk("req_seen", w < 5000, 1);
        repeat (H) @(negedge clock);
        pop_chk("start_bit");
        for (int k = 1; k <= edges; k++) begin
            if (k == 11 && ack_low) dev_dt = 0;
            repeat (H / 2) @(negedge clock);
            dev_ck = 0;
            repeat (H) @(negedge clock);
            dev_ck = 1;
            if (k < 11) begin
                pop_chk($sformatf("bit%0d", k));
                repeat (H / 2) @(negedge clock);
            end else dev_dt = 1;
        end
    endtask

    task automatic wait_pulse(input bit poke);
        int w = 0;
        while (!(done || error) && w < 3000) begin
            @(negedge clock);
            w++;
        end
        chk("pulse_seen", w < 3000, 1);
        if (poke) begin
            start = 1;
            data = 8'hFF;
            @(negedge clock);
            start = 0;
            repeat (4) @(negedge clock);
            chk("start_on_pulse_ignored", busy, 0);
            chk("start_on_pulse_ck", ps2CkOe, 0);
        end
        chk("idle_after", busy, 0);
    endtask

    // result scoreboard: every done/error pulse must match the next expected outcome
    always @(negedge clock) begin
        if (!reset && (done || error)) begin
            if (res_q.size() == 0) chk("pulse_unexpected", {done, error}, 2'b00);
            else chk("pulse_kind", {done, error}, res_q.pop_front());
            chk("busy_at_pulse", busy, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        start = 0;
        data = 0;
        dev_ck = 1;
        dev_dt = 1;
        repeat (5) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_ckoe", ps2CkOe, 0);
        chk("rst_dtoe", ps2DtOe, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 0;
        repeat (5) @(negedge clock);
        chk("idle_busy", busy, 0);

        send(8'hED, 1, 1);
        @(negedge clock);
        start = 1;
        data = 8'hFF;
        @(negedge clock);
        start = 0;
        dev_xfer(11, 1);
        wait_pulse(0);

        send(8'h00, 1, 1);
        dev_xfer(11, 1);
        wait_pulse(0);

        send(8'h01, 1, 1);
        dev_xfer(11, 1);
        wait_pulse(1);

        send(8'hA5, 1, 2);
        dev_xfer(11, 0);
        repeat (2) @(negedge clock);
        chk("nack_busy", busy, 0);
        chk("nack_ckoe", ps2CkOe, 0);
        chk("nack_dtoe", ps2DtOe, 0);

        send(8'h3C, 0, 2);
        ticks = 0;
        t = 0;
        while (!error && t < 4 * TMO) begin
            @(posedge clock);
            if (ce) ticks++;
            #1 t++;
        end
        chk("timeout_ticks", ticks, TMO);
        chk("timeout_ckoe", ps2CkOe, 0);
        chk("timeout_dtoe", ps2DtOe, 0);
        repeat (4) @(negedge clock);

        send(8'hED, 1, 0);
        dev_xfer(4, 1);
        dev_ck = 0;
        repeat (20) @(negedge clock);
        chk("bit4_drive", ps2DtOe, 1);
        #3 reset = 1;
        #1;
        chk("mid_rst_ckoe", ps2CkOe, 0);
        chk("mid_rst_dtoe", ps2DtOe, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clock);
        dev_ck = 1;
        repeat (3) @(negedge clock);
        reset = 0;
        exp_q.delete();
        repeat (5) @(negedge clock);

        send(8'h5A, 1, 1);
        dev_xfer(11, 1);
        wait_pulse(0);

`ifdef PS2TX_LED_EN
        @(negedge clock);
        push_bits(8'hED);
        push_bits(8'h01);
        res_q.push_back(2'b10);
        res_q.push_back(2'b10);
        leds = 3'b001;
        dev_xfer(11, 1);
        dev_xfer(11, 1);
        wait_pulse(0);
        t = 0;
        repeat (200) begin
            @(negedge clock);
            t = t | int'(busy);
        end
        chk("led_no_resend", t, 0);
`endif

        repeat (10) @(negedge clock);
        chk("bits_drained", exp_q.size(), 0);
        chk("results_drained", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
